// File: rtl/fifo_uart_tx.sv
// Drains a synchronous byte FIFO and serialises each popped word as a UART frame:
// start bit, DATA_W data bits LSB-first, optional even parity, STOP_BITS stop bits.
module fifo_uart_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_enable,
  input  logic              fifo_empty,
  input  logic              fifo_write_enable,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_read_enable,
  output logic              tx,
  output logic              busy,
  output logic              tx_done,
  output logic [15:0]       frame_count
);

  // state  | meaning
  // IDLE   | line idle, waiting for tx_enable with data in the FIFO
  // REQ    | read strobe high; held while the FIFO is taking a write
  // WAIT   | FIFO read data valid, captured into the shift register
  // START  | start bit (line low)
  // DATA   | data bits, LSB first
  // PARITY | even parity of the captured word
  // STOP   | stop bit(s); last cycle ends the frame

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, START, DATA, PARITY, STOP} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shift;
  logic              par;
  logic [CW-1:0]     baud;
  logic [BW-1:0]     bit_cnt;
  logic              tx_nxt;
  logic              baud_tc;
  logic              last_stop;
  logic              pop_ok;

  assign baud_tc          = (baud == '0);
  assign last_stop        = (state == STOP) && baud_tc && (bit_cnt == STOP_LAST);
  assign pop_ok           = tx_enable && !fifo_empty;
  assign fifo_read_enable = (state == REQ);
  assign busy             = (state != IDLE);

  always_comb begin
    state_nxt = state;
    tx_nxt    = 1'b1;
    case (state)
      IDLE:   if (pop_ok) state_nxt = REQ;
      REQ:    if (!fifo_write_enable) state_nxt = WAIT;
      WAIT:   state_nxt = START;
      START: begin
        tx_nxt = 1'b0;
        if (baud_tc) state_nxt = DATA;
      end
      DATA: begin
        tx_nxt = shift[0];
        if (baud_tc && (bit_cnt == DATA_LAST))
          state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: begin
        tx_nxt = par;
        if (baud_tc) state_nxt = STOP;
      end
      STOP:   if (last_stop) state_nxt = pop_ok ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The line register lags the state by one cycle, so tx falls one edge after START is entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      tx          <= 1'b1;
      tx_done     <= 1'b0;
      frame_count <= '0;
      shift       <= '0;
      par         <= 1'b0;
      baud        <= '0;
      bit_cnt     <= '0;
    end else begin
      state   <= state_nxt;
      tx      <= tx_nxt;
      tx_done <= last_stop;
      if (last_stop) frame_count <= frame_count + 16'd1;
      case (state)
        WAIT: begin
          shift   <= fifo_data;
          par     <= ^fifo_data;
          baud    <= BAUD_LAST;
          bit_cnt <= '0;
        end
        START, DATA, PARITY, STOP: begin
          if (baud_tc) begin
            baud <= BAUD_LAST;
            if (state == DATA) begin
              shift   <= shift >> 1;
              bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + BW'(1);
            end else if (state == STOP) begin
              bit_cnt <= bit_cnt + BW'(1);
            end else begin
              bit_cnt <= '0;
            end
          end else begin
            baud <= baud - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a behavioural FIFO and a line sampler.
module tb_fifo_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 44;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tx_enable = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        fifo_write_enable = 1'b0;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_read_enable;
  logic        tx;
  logic        busy;
  logic        tx_done;
  logic [15:0] frame_count;

  logic [7:0]  wr_data = 8'h00;
  logic        fifo_flush = 1'b0;
  logic [7:0]  q[$];
  int          rd_cycles = 0;
  int          rd_pulses = 0;
  logic        rd_prev = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [7:0]  burst [5];

  fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .tx_enable(tx_enable), .fifo_empty(fifo_empty),
    .fifo_write_enable(fifo_write_enable), .fifo_data(fifo_data),
    .fifo_read_enable(fifo_read_enable), .tx(tx), .busy(busy), .tx_done(tx_done),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // FIFO: a read in a write cycle is ignored; read data is registered.
  always @(posedge clk) begin
    if (fifo_flush) begin
      q.delete();
    end else begin
      if (fifo_read_enable && !fifo_write_enable && q.size() > 0) fifo_data <= q.pop_front();
      if (fifo_write_enable) q.push_back(wr_data);
    end
    fifo_empty <= (q.size() == 0);
  end

  always @(posedge clk) begin
    if (fifo_read_enable) rd_cycles++;
    if (fifo_read_enable && !rd_prev) rd_pulses++;
    rd_prev = fifo_read_enable;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    wr_data = b;
    fifo_write_enable = 1'b1;
    @(negedge clk);
    fifo_write_enable = 1'b0;
  endtask

  task automatic flush();
    @(negedge clk);
    fifo_flush = 1'b1;
    @(negedge clk);
    fifo_flush = 1'b0;
  endtask

  task automatic wait_start(input string tag, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (tx !== 1'b0 && waited < 400);
    chk({tag, "_start_seen"}, 32'(waited < 400), 32'd1);
  endtask

  // Samples one whole frame; returns in the negedge of its last stop cycle.
  task automatic recv_frame(input string tag, input logic [7:0] exp_b, input logic exp_par,
                            input int drop_at, output int waited);
    logic [10:0] mid;
    logic        e;
    int          bad, done_k, done_n;
    bad = 0; done_k = -1; done_n = 0; mid = '0;
    wait_start(tag, waited);
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) @(negedge clk);
      if (k == drop_at) tx_enable = 1'b0;
      if (k / CPB == 0)      e = 1'b0;
      else if (k / CPB < 9)  e = exp_b[k / CPB - 1];
      else if (k / CPB == 9) e = exp_par;
      else                   e = 1'b1;
      if (tx !== e) bad++;
      if (k % CPB == 1) mid[k / CPB] = tx;
      if (tx_done === 1'b1) begin
        done_n++;
        done_k = k;
      end
    end
    chk({tag, "_start_bit"}, 32'(mid[0]), 32'd0);
    chk({tag, "_data"}, 32'(mid[8:1]), 32'(exp_b));
    chk({tag, "_parity"}, 32'(mid[9]), 32'(exp_par));
    chk({tag, "_stop"}, 32'(mid[10]), 32'd1);
    chk({tag, "_bad_samples"}, 32'(bad), 32'd0);
    chk({tag, "_done_cycle"}, 32'(done_k), 32'(FRAME - 1));
    chk({tag, "_done_count"}, 32'(done_n), 32'd1);
  endtask

  initial begin
    int w;
    int rd0, rdc0;
    burst[0] = 8'h3C; burst[1] = 8'h11; burst[2] = 8'h22; burst[3] = 8'h33; burst[4] = 8'h44;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd", 32'(fifo_read_enable), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    rst = 1'b1;

    // T1: empty FIFO gives no pop; then 0xA5 with parity 0
    tx_enable = 1'b1;
    repeat (5) @(negedge clk);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_idle_rd", 32'(rd_cycles), 32'd0);
    push(8'hA5);
    recv_frame("t1", 8'hA5, 1'b0, -1, w);
    chk("t1_latency", 32'(w), 32'd4);
    chk("t1_count", 32'(frame_count), 32'd1);
    chk("t1_rd_pulses", 32'(rd_pulses), 32'd1);
    chk("t1_rd_cycles", 32'(rd_cycles), 32'd1);

    // T2: three back-to-back frames after a fresh reset
    tx_enable = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rd0 = rd_pulses;
    push(8'h01); push(8'h80); push(8'hFF);
    @(negedge clk);
    tx_enable = 1'b1;
    recv_frame("t2a", 8'h01, 1'b1, -1, w);
    chk("t2a_latency", 32'(w), 32'd4);
    recv_frame("t2b", 8'h80, 1'b1, -1, w);
    chk("t2b_gap", 32'(w), 32'd3);
    recv_frame("t2c", 8'hFF, 1'b0, -1, w);
    chk("t2c_gap", 32'(w), 32'd3);
    chk("t2_count", 32'(frame_count), 32'd3);
    repeat (4) @(negedge clk);
    chk("t2_rd_pulses", 32'(rd_pulses - rd0), 32'd3);
    chk("t2_idle_busy", 32'(busy), 32'd0);

    // T3: writes collide with REQ for three cycles
    rd0 = rd_pulses; rdc0 = rd_cycles;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      wr_data = burst[i];
      fifo_write_enable = 1'b1;
      @(negedge clk);
    end
    fifo_write_enable = 1'b0;
    tx_enable = 1'b0;
    recv_frame("t3", 8'h3C, 1'b0, -1, w);
    chk("t3_latency", 32'(w), 32'd3);
    repeat (4) @(negedge clk);
    chk("t3_rd_cycles", 32'(rd_cycles - rdc0), 32'd4);
    chk("t3_rd_pulses", 32'(rd_pulses - rd0), 32'd1);
    chk("t3_fifo_left", 32'(q.size()), 32'd4);
    chk("t3_busy", 32'(busy), 32'd0);
    flush();

    // T4: reset during data bit 3
    push(8'h5A); push(8'h77);
    tx_enable = 1'b1;
    wait_start("t4", w);
    repeat (17) @(negedge clk);
    rst = 1'b0;
    rdc0 = rd_cycles;
    @(negedge clk);
    chk("t4_tx", 32'(tx), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_count", 32'(frame_count), 32'd0);
    chk("t4_done", 32'(tx_done), 32'd0);
    repeat (3) @(negedge clk);
    chk("t4_rd_in_rst", 32'(rd_cycles - rdc0), 32'd0);
    rst = 1'b1;
    recv_frame("t4b", 8'h77, 1'b0, -1, w);
    chk("t4b_latency", 32'(w), 32'd4);
    chk("t4b_count", 32'(frame_count), 32'd1);

    // T5: tx_enable dropped mid-frame with two bytes queued
    tx_enable = 1'b0;
    repeat (4) @(negedge clk);
    push(8'hC3); push(8'h96);
    rd0 = rd_pulses;
    tx_enable = 1'b1;
    recv_frame("t5", 8'hC3, 1'b0, 10, w);
    repeat (10) @(negedge clk);
    chk("t5_fifo_left", 32'(q.size()), 32'd1);
    chk("t5_rd_pulses", 32'(rd_pulses - rd0), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_count", 32'(frame_count), 32'd2);
    flush();
    rd0 = rd_pulses;
    tx_enable = 1'b1;
    repeat (8) @(negedge clk);
    chk("t5_empty_rd", 32'(rd_pulses - rd0), 32'd0);
    chk("t5_empty_busy", 32'(busy), 32'd0);

    // T6: frame_count wraps
    force dut.frame_count = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count;
    @(negedge clk);
    chk("t6_preload", 32'(frame_count), 32'h0000FFFF);
    push(8'h00);
    recv_frame("t6", 8'h00, 1'b0, -1, w);
    chk("t6_latency", 32'(w), 32'd4);
    chk("t6_wrap", 32'(frame_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
